// File: rtl/stereo_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : stereo_sample_pacer
// Purpose  : Buffers stereo frames from a valid/ready source. A phase-
//            accumulator NCO releases them at a fractional rate to the MPX
//            generator, and the last frame repeats on underrun.
// Revision : 1.0 - initial release
// ============================================================================
module stereo_sample_pacer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [ACC_WIDTH-1:0]          rate_step,
    input  logic [DATA_WIDTH-1:0]         s_l,
    input  logic [DATA_WIDTH-1:0]         s_r,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_WIDTH-1:0]         out_l,
    output logic [DATA_WIDTH-1:0]         out_r,
    output logic                          out_valid,
    output logic                          out_valid_180,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          underrun_clear,
    output logic [15:0]                   underrun_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

    logic [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH:0]      w_sum;
    logic                    w_wrap;
    logic                    w_half;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;

    logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_LVL_W-1:0]      r_level;

    // Carry out of the phase add marks a new frame period; MSB rising alone marks mid-period.
    assign w_sum   = {1'b0, r_acc} + {1'b0, rate_step};
    assign w_wrap  = enable && w_sum[ACC_WIDTH];
    assign w_half  = enable && !r_acc[ACC_WIDTH-1] && w_sum[ACC_WIDTH-1] && !w_sum[ACC_WIDTH];

    assign w_empty    = (r_level == '0);
    assign s_ready    = (r_level != c_FULL);
    assign fifo_level = r_level;

    // Pop decision uses the pre-edge level, so a frame arriving on a wrap edge waits a period.
    assign w_push = s_valid && s_ready;
    assign w_pop  = w_wrap && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_l, s_r};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc          <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            out_l          <= '0;
            out_r          <= '0;
            out_valid      <= 1'b0;
            out_valid_180  <= 1'b0;
            underrun_count <= '0;
        end else begin
            if (enable) begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
            end

            out_valid     <= w_wrap;
            out_valid_180 <= w_half;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {out_l, out_r} <= r_mem[r_rd_ptr];
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (underrun_clear) begin
                underrun_count <= '0;
            end else if (w_wrap && w_empty && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stereo_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stereo_sample_pacer
// Purpose  : Scoreboard bench for stereo_sample_pacer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stereo_sample_pacer;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int FD = 4;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] rate_step;
    logic [DW-1:0] s_l, s_r;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] out_l, out_r;
    logic          out_valid, out_valid_180;
    logic [LW-1:0] fifo_level;
    logic          underrun_clear;
    logic [15:0]   underrun_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   exp_l = '0;
    logic [DW-1:0]   exp_r = '0;
    int              exp_under = 0;

    stereo_sample_pacer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rate_step(rate_step),
        .s_l(s_l), .s_r(s_r), .s_valid(s_valid), .s_ready(s_ready),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_valid_180(out_valid_180),
        .fifo_level(fifo_level), .underrun_clear(underrun_clear), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        s_l = l; s_r = r; s_valid = 1'b1;
        if (s_ready) exp_q.push_back({l, r});
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (out_l !== '0 || out_r !== '0) begin n_fail++;
            $display("FAIL reset_data: got %h/%h want 0/0", out_l, out_r); end
        n_checks++; if (out_valid !== 1'b0 || out_valid_180 !== 1'b0) begin n_fail++;
            $display("FAIL reset_strobes: got %b/%b want 0/0", out_valid, out_valid_180); end
        n_checks++; if (fifo_level !== '0) begin n_fail++;
            $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b want 1", s_ready); end
        n_checks++; if (underrun_count !== 16'd0) begin n_fail++;
            $display("FAIL reset_underrun: got %0d want 0", underrun_count); end
    endtask

    task automatic test_fill();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_frame(DW'(2*i+1), DW'(2*i+2));
        n_checks++; if (fifo_level !== LW'(4)) begin n_fail++;
            $display("FAIL fill_level: got %0d want 4", fifo_level); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++;
            $display("FAIL fill_ready: got %b want 0", s_ready); end
        push_frame(16'hDEAD, 16'hBEEF);
        n_checks++; if (fifo_level !== LW'(4) || exp_q.size() != 4) begin n_fail++;
            $display("FAIL full_push_ignored: level %0d want 4", fifo_level); end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (out_valid !== 1'b0 || out_valid_180 !== 1'b0) begin n_fail++;
            $display("FAIL disabled_strobes: got %b/%b want 0/0", out_valid, out_valid_180); end
    endtask

    task automatic test_drain_and_underrun();
        int cyc = 0;
        int last_v = 0;
        int events = 0;
        rate_step = 32'h4000_0000;
        enable = 1'b1;
        while (events < 7 && cyc < 200) begin
            tick(); cyc++;
            if (out_valid && out_valid_180) begin n_checks++; n_fail++;
                $display("FAIL strobe_coincident: cycle %0d both high, want exclusive", cyc); end
            if (out_valid_180) begin
                n_checks++; if (cyc - last_v != 2) begin n_fail++;
                    $display("FAIL half_phase: got %0d clks after frame want 2", cyc - last_v); end
            end
            if (out_valid) begin
                n_checks++; if (cyc - last_v != 4) begin n_fail++;
                    $display("FAIL frame_cadence: got %0d clks want 4", cyc - last_v); end
                if (exp_q.size() > 0) {exp_l, exp_r} = exp_q.pop_front();
                else exp_under++;
                n_checks++; if (out_l !== exp_l || out_r !== exp_r) begin n_fail++;
                    $display("FAIL frame_data: got %0d/%0d want %0d/%0d", out_l, out_r, exp_l, exp_r); end
                n_checks++; if (underrun_count !== 16'(exp_under)) begin n_fail++;
                    $display("FAIL underrun_count: got %0d want %0d", underrun_count, exp_under); end
                last_v = cyc;
                events++;
            end
        end
        if (cyc >= 200) begin n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d events want 7", events); end
        underrun_clear = 1'b1;
        tick();
        underrun_clear = 1'b0;
        exp_under = 0;
        n_checks++; if (underrun_count !== 16'd0) begin n_fail++;
            $display("FAIL underrun_clear: got %0d want 0", underrun_count); end
    endtask

    // Phase is one quarter into the period on entry.
    task automatic test_enable_pause();
        logic seen = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid || out_valid_180) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || underrun_count !== 16'd0) begin n_fail++;
            $display("FAIL pause_strobes: strobe %b count %0d want 0/0", seen, underrun_count); end
        enable = 1'b1;
        tick();
        n_checks++; if (out_valid_180 !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL resume_half: got %b/%b want v=0 h=1", out_valid, out_valid_180); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL resume_early: got out_valid %b want 0", out_valid); end
        tick();
        exp_under++;
        n_checks++; if (out_valid !== 1'b1 || underrun_count !== 16'(exp_under)) begin n_fail++;
            $display("FAIL resume_wrap: got v=%b count %0d want 1/%0d", out_valid, underrun_count, exp_under); end
        n_checks++; if (out_l !== exp_l || out_r !== exp_r) begin n_fail++;
            $display("FAIL resume_hold: got %0d/%0d want %0d/%0d", out_l, out_r, exp_l, exp_r); end
    endtask

    task automatic test_saturate();
        rate_step = 32'hFFFF_FFFF;
        for (int i = 0; i < 65600; i++) tick();
        n_checks++; if (underrun_count !== 16'hFFFF) begin n_fail++;
            $display("FAIL saturate: got %h want ffff", underrun_count); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (underrun_count !== 16'hFFFF) begin n_fail++;
            $display("FAIL saturate_hold: got %h want ffff", underrun_count); end
        underrun_clear = 1'b1;
        tick();
        underrun_clear = 1'b0;
        n_checks++; if (underrun_count !== 16'd0 || out_valid !== 1'b1) begin n_fail++;
            $display("FAIL clear_on_wrap: count %h wrap %b want 0/1", underrun_count, out_valid); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        rate_step = 32'h4000_0000;
        tick();
        for (int i = 0; i < 3; i++) push_frame(DW'(100+i), DW'(200+i));
        n_checks++; if (fifo_level !== LW'(3)) begin n_fail++;
            $display("FAIL pre_reset_level: got %0d want 3", fifo_level); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_l = '0; exp_r = '0; exp_under = 0;
        test_reset();
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++; if (out_valid !== (i == 4)) begin n_fail++;
                $display("FAIL post_reset_period: clk %0d got %b want %b", i, out_valid, (i == 4)); end
        end
        n_checks++; if (out_l !== '0 || underrun_count !== 16'd1) begin n_fail++;
            $display("FAIL post_reset_underrun: got %0d count %0d want 0/1", out_l, underrun_count); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rate_step = '0;
        s_l = '0; s_r = '0; s_valid = 1'b0; underrun_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_fill();
        test_drain_and_underrun();
        test_enable_pause();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
